// File: rtl/ethpipe_pkg.sv
// Shared definitions for the ethpipe RX slot path: slot word offsets,
// reader FSM states and the last-beat byte-enable helper.
package ethpipe_pkg;

  localparam int unsigned SLOT_TS_LO = 1;
  localparam int unsigned SLOT_TS_HI = 2;
  localparam int unsigned SLOT_HASH  = 3;
  localparam int unsigned SLOT_LEN   = 4;
  localparam int unsigned SLOT_DATA  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
    ST_DATA,
    ST_RELEASE
  } rx_state_t;

  // Byte lanes valid in the final beat, given length modulo 4.
  function automatic logic [3:0] keep_from_rem(input logic [1:0] rem);
    logic [3:0] keep;
    case (rem)
      2'd1:    keep = 4'b0001;
      2'd2:    keep = 4'b0011;
      2'd3:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/ethpipe_skid_buf.sv
// Two-entry valid/ready buffer carrying {tlast, tkeep, tdata} beats.
// The writer must use 'level' to avoid pushing into a full buffer; the
// head entry is held stable on the output until it is accepted.
module ethpipe_skid_buf #(
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   level
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = rd_ptr ? entry1 : entry0;
  assign level     = count;
  assign push      = in_valid && (count != 2'd2);
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy; entries clear on reset so outputs read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0 <= '0;
      entry1 <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) entry1 <= in_data;
        else        entry0 <= in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ethpipe_rx_slot_reader.sv
// Drains a completed GMII RX slot into a 32-bit valid/ready stream with
// timestamp/hash/length sideband, then hands the slot back to the receiver.
// Optional build macro ETHPIPE_RX_STRIP_FCS_EN removes the 4 FCS bytes.
module ethpipe_rx_slot_reader
  import ethpipe_pkg::*;
#(
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned MIN_LEN = 14
) (
  input  logic              pci_clk,
  input  logic              sys_rst_n,
  input  logic              slot_rx_complete,
  output logic              slot_rx_empty,
  output logic [ADDR_W-1:0] slot_rd_address,
  input  logic [31:0]       slot_rd_q,
  output logic [63:0]       rx_meta_ts,
  output logic [31:0]       rx_meta_hash,
  output logic [10:0]       rx_meta_len,
  output logic [31:0]       rx_tdata,
  output logic [3:0]        rx_tkeep,
  output logic              rx_tvalid,
  output logic              rx_tlast,
  input  logic              rx_tready,
  output logic [15:0]       rx_drop_cnt
);

  localparam int unsigned WCNT_W    = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = (1 << ADDR_W) - SLOT_DATA;

  rx_state_t         state;
  rx_state_t         state_next;
  logic [2:0]        hdr_cnt;
  logic [WCNT_W-1:0] words_left;
  logic [3:0]        last_keep;
  logic              rd_valid_d;
  logic              rd_last_d;
  logic [3:0]        rd_keep_d;
  logic              start;
  logic              issue;
  logic              drop_frame;
  logic              stray;
  logic              beat_accept;
  logic              too_short;
  logic              clamp;
  logic [11:0]       words_raw;
  logic [1:0]        level;
  logic [2:0]        credit_used;
  logic [2:0]        credit_limit;
  logic [36:0]       buf_out;
  logic [16:0]       drop_sum;

  // Effective frame length after optional FCS removal.
  function automatic logic [10:0] eff_len(input logic [10:0] raw);
`ifdef ETHPIPE_RX_STRIP_FCS_EN
    return (raw < 11'd4) ? 11'd0 : raw - 11'd4;
`else
    return raw;
`endif
  endfunction

  assign words_raw    = ({1'b0, rx_meta_len} + 12'd3) >> 2;
  assign clamp        = ({20'd0, words_raw} > MAX_WORDS);
  assign too_short    = ({21'd0, rx_meta_len} < MIN_LEN) || (words_raw == 12'd0);
  assign beat_accept  = rx_tvalid && rx_tready;
  assign stray        = slot_rx_complete && (state != ST_IDLE);
  assign credit_used  = {1'b0, level} + {2'b00, rd_valid_d};
  assign credit_limit = 3'd1 + {2'b00, beat_accept};
  assign drop_sum     = {1'b0, rx_drop_cnt} + {16'd0, drop_frame} + {16'd0, stray};

  // State register.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  // Next-state and per-cycle control; reads are issued only while the
  // buffer plus the in-flight read leave room for the returning word.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    issue      = 1'b0;
    drop_frame = 1'b0;
    case (state)
      ST_IDLE: begin
        if (slot_rx_complete) begin
          start      = 1'b1;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (hdr_cnt == 3'd4) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (too_short) begin
          drop_frame = 1'b1;
          state_next = ST_RELEASE;
        end else begin
          state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        issue = (words_left != '0) && (credit_used <= credit_limit);
        if (beat_accept && rx_tlast) state_next = ST_RELEASE;
      end
      ST_RELEASE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Header phase counter: address k+1 is presented when hdr_cnt==k.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)           hdr_cnt <= 3'd0;
    else if (state == ST_HDR) hdr_cnt <= hdr_cnt + 3'd1;
    else                      hdr_cnt <= 3'd0;
  end

  // Read address: walks the header, parks on the first data word, then advances per issued read.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                                slot_rd_address <= '0;
    else if (start)                                slot_rd_address <= ADDR_W'(SLOT_TS_LO);
    else if ((state == ST_HDR) && (hdr_cnt < 3'd4)) slot_rd_address <= slot_rd_address + 1'b1;
    else if (issue)                                slot_rd_address <= slot_rd_address + 1'b1;
    else if (state == ST_RELEASE)                  slot_rd_address <= '0;
  end

  // Header capture, one cycle behind each header address.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta_ts   <= '0;
      rx_meta_hash <= '0;
      rx_meta_len  <= '0;
    end else if (state == ST_HDR) begin
      case (hdr_cnt)
        3'd1:    rx_meta_ts[31:0]  <= slot_rd_q;
        3'd2:    rx_meta_ts[63:32] <= slot_rd_q;
        3'd3:    rx_meta_hash      <= slot_rd_q;
        3'd4:    rx_meta_len       <= eff_len(slot_rd_q[10:0]);
        default: ;
      endcase
    end
  end

  // Remaining data words and last-beat byte enables, clamped to the slot end.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      words_left <= '0;
      last_keep  <= 4'b0000;
    end else if (state == ST_CHECK) begin
      words_left <= clamp ? WCNT_W'(MAX_WORDS) : WCNT_W'(words_raw);
      last_keep  <= clamp ? 4'b1111 : keep_from_rem(rx_meta_len[1:0]);
    end else if (issue) begin
      words_left <= words_left - 1'b1;
    end
  end

  // Tags travelling alongside each read so they line up with the returned word.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_valid_d <= 1'b0;
      rd_last_d  <= 1'b0;
      rd_keep_d  <= 4'b0000;
    end else begin
      rd_valid_d <= issue;
      rd_last_d  <= issue && (words_left == WCNT_W'(1));
      rd_keep_d  <= (words_left == WCNT_W'(1)) ? last_keep : 4'b1111;
    end
  end

  // Slot ownership: taken when a frame starts, returned after the frame or drop.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)               slot_rx_empty <= 1'b1;
    else if (start)               slot_rx_empty <= 1'b0;
    else if (state == ST_RELEASE) slot_rx_empty <= 1'b1;
  end

  // Saturating count of short frames and completion pulses seen while busy.
  always_ff @(posedge pci_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       rx_drop_cnt <= 16'd0;
    else if (drop_sum[16]) rx_drop_cnt <= 16'hFFFF;
    else                  rx_drop_cnt <= drop_sum[15:0];
  end

  ethpipe_skid_buf #(.W(37)) u_skid (
    .clk       (pci_clk),
    .rst_n     (sys_rst_n),
    .in_valid  (rd_valid_d),
    .in_data   ({rd_last_d, rd_keep_d, slot_rd_q}),
    .out_valid (rx_tvalid),
    .out_data  (buf_out),
    .out_ready (rx_tready),
    .level     (level)
  );

  assign rx_tlast = buf_out[36];
  assign rx_tkeep = buf_out[35:32];
  assign rx_tdata = buf_out[31:0];

endmodule

// File: tb/tb_ethpipe_rx_slot_reader.sv
// Scoreboard bench for ethpipe_rx_slot_reader: a slot RAM model feeds
// randomized frames, expected beats are queued from the frame rules and
// a monitor compares every accepted beat. Honours ETHPIPE_RX_STRIP_FCS_EN.
module tb_ethpipe_rx_slot_reader;

  localparam int MIN_LEN = 14;

  logic        pci_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        slot_rx_complete = 1'b0;
  logic        slot_rx_empty;
  logic [10:0] slot_rd_address;
  logic [31:0] slot_rd_q = 32'd0;
  logic [63:0] rx_meta_ts;
  logic [31:0] rx_meta_hash;
  logic [10:0] rx_meta_len;
  logic [31:0] rx_tdata;
  logic [3:0]  rx_tkeep;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready = 1'b1;
  logic [15:0] rx_drop_cnt;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        first;
    logic [63:0] ts;
    logic [31:0] hash;
    logic [10:0] len;
  } beat_t;

  beat_t       expQ[$];
  logic [31:0] mem [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          dropExp = 0;
  bit          readyRandom = 1'b0;
  int          cycle = 0;
  int          firstCyc = 0;
  int          lastCyc = 0;

  ethpipe_rx_slot_reader #(.ADDR_W(11), .MIN_LEN(MIN_LEN)) dut (
    .pci_clk          (pci_clk),
    .sys_rst_n        (sys_rst_n),
    .slot_rx_complete (slot_rx_complete),
    .slot_rx_empty    (slot_rx_empty),
    .slot_rd_address  (slot_rd_address),
    .slot_rd_q        (slot_rd_q),
    .rx_meta_ts       (rx_meta_ts),
    .rx_meta_hash     (rx_meta_hash),
    .rx_meta_len      (rx_meta_len),
    .rx_tdata         (rx_tdata),
    .rx_tkeep         (rx_tkeep),
    .rx_tvalid        (rx_tvalid),
    .rx_tlast         (rx_tlast),
    .rx_tready        (rx_tready),
    .rx_drop_cnt      (rx_drop_cnt)
  );

  always #4 pci_clk = ~pci_clk;

  // Slot RAM read port with one cycle of latency.
  always @(posedge pci_clk) slot_rd_q <= mem[slot_rd_address];

  // Sink ready: constant or coin-flip, changed away from both clock edges.
  initial begin
    forever begin
      @(posedge pci_clk);
      #2;
      rx_tready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int effLen(input int raw);
`ifdef ETHPIPE_RX_STRIP_FCS_EN
    return (raw < 4) ? 0 : raw - 4;
`else
    return raw;
`endif
  endfunction

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge pci_clk) begin
    cycle++;
    if (sys_rst_n && rx_tvalid && rx_tready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_beat", 64'(rx_tdata), 64'hDEAD_0000_0000);
      end else begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("tdata", 64'(rx_tdata), 64'(e.data));
        checkOutput("tkeep", 64'(rx_tkeep), 64'(e.keep));
        checkOutput("tlast", 64'(rx_tlast), 64'(e.last));
        checkOutput("meta_ts", rx_meta_ts, e.ts);
        checkOutput("meta_hash", 64'(rx_meta_hash), 64'(e.hash));
        checkOutput("meta_len", 64'(rx_meta_len), 64'(e.len));
        if (e.first) firstCyc = cycle;
        if (e.last)  lastCyc = cycle;
      end
    end
  end

  task automatic waitEmpty(input logic val, input int limit, input string name);
    int n = 0;
    while (slot_rx_empty !== val && n < limit) begin
      @(negedge pci_clk);
      n++;
    end
    checkOutput(name, 64'(slot_rx_empty), 64'(val));
  endtask

  task automatic pulseComplete();
    @(negedge pci_clk);
    slot_rx_complete = 1'b1;
    @(negedge pci_clk);
    slot_rx_complete = 1'b0;
  endtask

  // Load a frame into the slot, queue its expected beats, start it.
  task automatic loadFrame(input int lenField, output int nw, output bit dropped);
    logic [63:0] ts;
    logic [31:0] hash;
    int          L;
    ts = {$urandom, $urandom};
    hash = $urandom;
    L = effLen(lenField);
    nw = (L + 3) / 4;
    mem[1] = ts[31:0];
    mem[2] = ts[63:32];
    mem[3] = hash;
    mem[4] = ($urandom & 32'hFFFF_F800) | 32'(lenField);
    for (int i = 0; i < 600; i++) mem[5 + i] = $urandom;
    dropped = (L < MIN_LEN);
    if (dropped) begin
      dropExp++;
    end else begin
      for (int i = 0; i < nw; i++) begin
        beat_t b;
        int    bytes;
        bytes = (i == nw - 1) ? L - 4 * (nw - 1) : 4;
        b.data = mem[5 + i];
        b.keep = 4'((1 << bytes) - 1);
        b.last = (i == nw - 1);
        b.first = (i == 0);
        b.ts = ts;
        b.hash = hash;
        b.len = 11'(L);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input int lenField, input bit rnd, input int strayAfter);
    int nw;
    bit dropped;
    readyRandom = rnd;
    loadFrame(lenField, nw, dropped);
    pulseComplete();
    waitEmpty(1'b0, 10, "slot_taken");
    if (strayAfter > 0) begin
      repeat (strayAfter) @(negedge pci_clk);
      dropExp++;
      pulseComplete();
    end
    waitEmpty(1'b1, 4000, "slot_released");
    @(negedge pci_clk);
    checkOutput("drop_cnt", 64'(rx_drop_cnt), 64'(dropExp));
    checkOutput("beats_pending", 64'(expQ.size()), 64'd0);
    if (!rnd && !dropped) checkOutput("throughput", 64'(lastCyc - firstCyc), 64'(nw - 1));
    expQ.delete();
  endtask

  initial begin
    int nw;
    bit dropped;
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    #1 sys_rst_n = 1'b0;
    #20;
    checkOutput("rst_empty", 64'(slot_rx_empty), 64'd1);
    checkOutput("rst_addr", 64'(slot_rd_address), 64'd0);
    checkOutput("rst_tvalid", 64'(rx_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(rx_tlast), 64'd0);
    checkOutput("rst_tkeep", 64'(rx_tkeep), 64'd0);
    checkOutput("rst_ts", rx_meta_ts, 64'd0);
    checkOutput("rst_hash", 64'(rx_meta_hash), 64'd0);
    checkOutput("rst_len", 64'(rx_meta_len), 64'd0);
    checkOutput("rst_drop", 64'(rx_drop_cnt), 64'd0);
    @(negedge pci_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge pci_clk);

    applyStimulus(64, 1'b0, 0);
    applyStimulus(61, 1'b0, 0);
    applyStimulus(10, 1'b0, 0);
    applyStimulus(13, 1'b0, 0);
    applyStimulus(14, 1'b0, 0);
    applyStimulus(3, 1'b0, 0);
    applyStimulus(68, 1'b0, 0);
    applyStimulus(64, 1'b1, 0);
    applyStimulus(64, 1'b0, 8);
    applyStimulus(2047, 1'b0, 0);
    for (int k = 0; k < 12; k++) applyStimulus($urandom_range(1, 300), 1'b1, 0);

    // Abort a frame mid-stream with reset, then confirm a clean restart.
    readyRandom = 1'b0;
    loadFrame(200, nw, dropped);
    pulseComplete();
    waitEmpty(1'b0, 10, "abort_taken");
    repeat (15) @(posedge pci_clk);
    #1 sys_rst_n = 1'b0;
    #1;
    checkOutput("abort_tvalid", 64'(rx_tvalid), 64'd0);
    checkOutput("abort_empty", 64'(slot_rx_empty), 64'd1);
    checkOutput("abort_drop", 64'(rx_drop_cnt), 64'd0);
    expQ.delete();
    dropExp = 0;
    @(negedge pci_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge pci_clk);
    applyStimulus(61, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule
